// File: rtl/wb_fetch_unit.sv
// ---------------------------------------------------------------------------
// wb_fetch_unit
//
// Instruction fetch stage. Issues classic single-read Wishbone cycles at
// sequential word addresses and buffers the returned words in a small
// prefetch FIFO. The core drains the FIFO through a valid/ready handshake.
// A redirect reloads the fetch PC and flushes the FIFO. A bus error, or too
// many consecutive retries, pushes an error marker and halts fetching until
// the next redirect.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   redirect_i            load redirect_pc_i (word aligned) and flush FIFO
//   redirect_pc_i         new fetch PC, bits [1:0] ignored
//   instr_valid_o         FIFO head valid
//   instr_o               head instruction word (unswapped)
//   instr_pc_o            address the head word was fetched from
//   instr_err_o           head entry is a bus error marker (instr_o = 0)
//   instr_ready_i         core pops head when instr_valid_o & instr_ready_i
//   cyc_o, stb_o          Wishbone cycle / strobe (always equal)
//   adr_o                 Wishbone byte address, bits [1:0] = 0
//   sel_o, dat_o, we_o    constant 4'b1111 / 0 / 0 (read-only master)
//   dat_i                 read data, sampled only with ack_i
//   ack_i, err_i, rty_i   terminations, priority err > rty > ack
// ---------------------------------------------------------------------------
module wb_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          RETRY_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_err_o,
  input  logic        instr_ready_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [31:0] adr_o,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  output logic        we_o,
  input  logic [31:0] dat_i,
  input  logic        ack_i,
  input  logic        err_i,
  input  logic        rty_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RTY_W = $clog2(RETRY_LIMIT + 1);

  // Retry count value at which the next rty is promoted to an error.
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(RETRY_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUS     = 2'd1,
    S_DISCARD = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // Control state
  state_t           state;
  logic [31:0]      fetch_pc;
  logic [RTY_W-1:0] rty_cnt;

  // FIFO control
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;

  // FIFO storage (data path, not reset)
  logic [31:0] mem_data [FIFO_DEPTH];
  logic [31:0] mem_pc   [FIFO_DEPTH];
  logic        mem_err  [FIFO_DEPTH];

  // Combinational decisions
  logic             term;
  logic             credit;
  logic [CNT_W:0]   occupancy;
  logic             push_en;
  logic             push_err;
  logic [31:0]      push_data;
  logic             pop_en;
  logic             rty_exhausted;

  // Constant master outputs: read-only, full-word accesses.
  assign stb_o = cyc_o;
  assign sel_o = 4'b1111;
  assign dat_o = 32'h0000_0000;
  assign we_o  = 1'b0;

  // Terminations only mean anything while a cycle is open; this also makes
  // a late response after a reset or a dropped cycle harmless.
  assign term = cyc_o & (ack_i | err_i | rty_i);

  // Entries buffered plus the one possibly in flight must leave room, so a
  // response can always be pushed without a full check.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, cyc_o};
  assign credit    = occupancy < (CNT_W + 1)'(FIFO_DEPTH);

  assign rty_exhausted = (rty_cnt == RTY_LAST);

  assign instr_valid_o = (fifo_count != '0);
  assign pop_en        = instr_valid_o & instr_ready_i & ~redirect_i;

  // Head outputs come straight from the storage registers.
  assign instr_o     = mem_data[rd_ptr];
  assign instr_pc_o  = mem_pc[rd_ptr];
  assign instr_err_o = instr_valid_o & mem_err[rd_ptr];

  // Push decision for the response being sampled on this edge. A redirect
  // on the same edge wins: the response belongs to the old stream.
  always_comb begin
    push_en   = 1'b0;
    push_err  = 1'b0;
    push_data = 32'h0000_0000;
    if (state == S_BUS && term && !redirect_i) begin
      if (err_i) begin
        push_en  = 1'b1;
        push_err = 1'b1;
      end else if (rty_i) begin
        if (rty_exhausted) begin
          push_en  = 1'b1;
          push_err = 1'b1;
        end
      end else begin
        push_en   = 1'b1;
        push_data = dat_i;
      end
    end
  end

  // ---- Fetch FSM: bus cycle control and fetch PC ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      cyc_o    <= 1'b0;
      adr_o    <= word_align(RESET_PC);
      fetch_pc <= word_align(RESET_PC);
      rty_cnt  <= '0;
    end else begin
      if (redirect_i) begin
        fetch_pc <= word_align(redirect_pc_i);
        rty_cnt  <= '0;
      end

      unique case (state)
        S_IDLE: begin
          // Redirect in IDLE only reloads the PC; the new request goes out
          // on a later edge.
          if (!redirect_i && credit) begin
            cyc_o <= 1'b1;
            adr_o <= fetch_pc;
            state <= S_BUS;
          end
        end

        S_BUS: begin
          if (redirect_i) begin
            // Close an already-terminating cycle directly; otherwise keep
            // cyc up and throw the response away when it comes.
            if (term) begin
              cyc_o <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_DISCARD;
            end
          end else if (term) begin
            cyc_o <= 1'b0;
            if (err_i) begin
              state <= S_HALT;
            end else if (rty_i) begin
              if (rty_exhausted) begin
                rty_cnt <= '0;
                state   <= S_HALT;
              end else begin
                // Same address is reissued from IDLE.
                rty_cnt <= rty_cnt + RTY_W'(1);
                state   <= S_IDLE;
              end
            end else begin
              fetch_pc <= fetch_pc + 32'd4;
              rty_cnt  <= '0;
              state    <= S_IDLE;
            end
          end
        end

        S_DISCARD: begin
          // Any termination closes the stale cycle; nothing is pushed.
          if (term) begin
            cyc_o <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_HALT: begin
          if (redirect_i) begin
            state <= S_IDLE;
          end
        end

        default: begin
          cyc_o <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // ---- Prefetch FIFO control ----
  always_ff @(posedge clk_i) begin
    if (rst_i || redirect_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push_en, pop_en})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---- Prefetch FIFO storage ----
  always_ff @(posedge clk_i) begin
    if (push_en) begin
      mem_data[wr_ptr] <= push_data;
      mem_pc[wr_ptr]   <= adr_o;
      mem_err[wr_ptr]  <= push_err;
    end
  end

endmodule

// File: tb/tb_wb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_wb_fetch_unit
//
// Directed bench for wb_fetch_unit with default parameters (RESET_PC 0,
// FIFO_DEPTH 4, RETRY_LIMIT 8). A registered Wishbone slave answers one
// clock after it sees cyc/stb and can be stalled, told to retry, or told to
// return an error at one address. A monitor logs every bus cycle start
// address and every popped FIFO entry.
// ---------------------------------------------------------------------------
module tb_wb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_err_o;
  logic        instr_ready_i;
  logic        cyc_o;
  logic        stb_o;
  logic [31:0] adr_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_o;
  logic        we_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_err_o   (instr_err_o),
    .instr_ready_i (instr_ready_i),
    .cyc_o         (cyc_o),
    .stb_o         (stb_o),
    .adr_o         (adr_o),
    .sel_o         (sel_o),
    .dat_o         (dat_o),
    .we_o          (we_o),
    .dat_i         (dat_i),
    .ack_i         (ack_i),
    .err_i         (err_i),
    .rty_i         (rty_i)
  );

  // Slave controls, written only by the stimulus process
  logic        stall       = 1'b0;
  logic        rty_forever = 1'b0;
  logic        err_en      = 1'b0;
  logic [31:0] err_adr     = 32'h0;
  logic        late_ack    = 1'b0;
  int          rty_req     = 0;

  // Slave state, written only by the slave process
  logic        ack_r      = 1'b0;
  logic        err_r      = 1'b0;
  logic        rty_r      = 1'b0;
  logic [31:0] dat_r      = 32'h0;
  int          rty_issued = 0;

  // Flash contents: two fixed words, elsewhere {~addr[15:0], addr[15:0]}.
  function automatic logic [31:0] flash_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h1122_3344;
    if (a == 32'h4) return 32'h5566_7788;
    return {~a[15:0], a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (ack_r || err_r || rty_r) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      rty_r <= 1'b0;
    end else if (cyc_o && stb_o && !stall) begin
      if (err_en && adr_o == err_adr) begin
        err_r <= 1'b1;
      end else if (rty_forever || rty_issued < rty_req) begin
        rty_r      <= 1'b1;
        rty_issued <= rty_issued + 1;
      end else begin
        ack_r      <= 1'b1;
        dat_r      <= flash_word(adr_o);
        rty_issued <= 0;
      end
    end
  end

  assign ack_i = ack_r | late_ack;
  assign err_i = err_r;
  assign rty_i = rty_r;
  assign dat_i = ack_r ? dat_r : 32'hDEAD_BEEF;

  // Monitor
  logic [31:0] adr_log [$];
  logic [31:0] pop_pc  [$];
  logic [31:0] pop_dat [$];
  logic        pop_err [$];
  logic        cyc_prev = 1'b0;

  always @(posedge clk) begin
    cyc_prev <= cyc_o;
    if (cyc_o && !cyc_prev) adr_log.push_back(adr_o);
    if (!rst_i && !redirect_i && instr_valid_o && instr_ready_i) begin
      pop_pc.push_back(instr_pc_o);
      pop_dat.push_back(instr_o);
      pop_err.push_back(instr_err_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Park the master in a stalled bus cycle, redirect it (BUS -> DISCARD),
  // let the stale cycle terminate and return with the FIFO empty and the
  // master in IDLE; the next edge starts the cycle at pc.
  task automatic restart(input logic [31:0] pc);
    int n;
    instr_ready_i = 1'b1;
    stall = 1'b1;
    ticks(2);
    n = 0;
    while (!cyc_o && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL restart_wait_cyc cyc_o=%0b required 1", cyc_o);
    end
    redirect_i = 1'b1;
    redirect_pc_i = pc;
    tick();
    redirect_i = 1'b0;
    stall = 1'b0;
    ticks(2);
  endtask

  // Redirect out of HALT; the next edge starts the cycle at pc.
  task automatic restart_halt(input logic [31:0] pc);
    redirect_i = 1'b1;
    redirect_pc_i = pc;
    tick();
    redirect_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b1;
    ticks(3);
    checks++;
    if ({cyc_o, stb_o, instr_valid_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl cyc/stb/valid=%b required 000", {cyc_o, stb_o, instr_valid_o});
    end
    checks++;
    if (adr_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_adr adr_o=%h required 00000000", adr_o);
    end
    checks++;
    if ({sel_o, we_o, dat_o} !== {4'b1111, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_const sel=%b we=%b dat=%h required 1111 0 0", sel_o, we_o, dat_o);
    end
  endtask

  task automatic test_stream();
    rst_i = 1'b0;
    tick();  // E0
    checks++;
    if (cyc_o !== 1'b1 || stb_o !== 1'b1 || adr_o !== 32'h0) begin
      errors++;
      $display("FAIL stream_e0 cyc=%b stb=%b adr=%h required 1 1 00000000", cyc_o, stb_o, adr_o);
    end
    tick();  // E1: slave ack registered
    checks++;
    if (instr_valid_o !== 1'b0 || cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL stream_e1 valid=%b cyc=%b required 0 1", instr_valid_o, cyc_o);
    end
    tick();  // E2: push
    checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== 32'h1122_3344 || instr_err_o !== 1'b0) begin
      errors++;
      $display("FAIL stream_first valid=%b pc=%h instr=%h err=%b required 1 00000000 11223344 0",
               instr_valid_o, instr_pc_o, instr_o, instr_err_o);
    end
    checks++;
    if (cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL stream_idle_gap cyc_o=%b required 0", cyc_o);
    end
    tick();  // E3: pop, next cycle starts
    checks++;
    if (cyc_o !== 1'b1 || adr_o !== 32'h4 || instr_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL stream_e3 cyc=%b adr=%h valid=%b required 1 00000004 0", cyc_o, adr_o, instr_valid_o);
    end
    ticks(2);  // E5: second push
    checks++;
    if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h4 || instr_o !== 32'h5566_7788) begin
      errors++;
      $display("FAIL stream_second valid=%b pc=%h instr=%h required 1 00000004 55667788",
               instr_valid_o, instr_pc_o, instr_o);
    end
  endtask

  task automatic test_backpressure();
    int s, p;
    logic [31:0] exp_pc  [4];
    logic [31:0] exp_dat [4];
    exp_pc  = '{32'h0, 32'h4, 32'h8, 32'hC};
    exp_dat = '{32'h1122_3344, 32'h5566_7788, 32'hFFF7_0008, 32'hFFF3_000C};
    restart(32'h0);
    instr_ready_i = 1'b0;
    s = adr_log.size();
    p = pop_pc.size();
    ticks(30);
    checks++;
    if (adr_log.size() - s != 4) begin
      errors++;
      $display("FAIL bp_cycle_count cycles=%0d required 4", adr_log.size() - s);
    end
    checks++;
    if (cyc_o !== 1'b0 || instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== 32'h1122_3344) begin
      errors++;
      $display("FAIL bp_hold cyc=%b valid=%b pc=%h instr=%h required 0 1 00000000 11223344",
               cyc_o, instr_valid_o, instr_pc_o, instr_o);
    end
    instr_ready_i = 1'b1;
    ticks(12);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pop_pc.size() <= p + i) begin
        errors++;
        $display("FAIL bp_pop%0d missing entry required pc %h", i, exp_pc[i]);
      end else if (pop_pc[p+i] !== exp_pc[i] || pop_dat[p+i] !== exp_dat[i]) begin
        errors++;
        $display("FAIL bp_pop%0d pc=%h dat=%h required %h %h", i, pop_pc[p+i], pop_dat[p+i], exp_pc[i], exp_dat[i]);
      end
    end
    checks++;
    if (adr_log.size() <= s + 4) begin
      errors++;
      $display("FAIL bp_resume no cycle after drain required adr 00000010");
    end else if (adr_log[s+4] !== 32'h10) begin
      errors++;
      $display("FAIL bp_resume adr=%h required 00000010", adr_log[s+4]);
    end
  endtask

  task automatic test_redirect();
    int n, s, p;
    instr_ready_i = 1'b0;
    n = 0;
    while (!instr_valid_o && n < 40) begin
      tick();
      n++;
    end
    stall = 1'b1;
    ticks(2);
    n = 0;
    while (!cyc_o && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (instr_valid_o !== 1'b1 || cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL redir_setup valid=%b cyc=%b required 1 1", instr_valid_o, cyc_o);
    end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0102;
    tick();
    redirect_i = 1'b0;
    checks++;
    if (instr_valid_o !== 1'b0 || cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL redir_flush valid=%b cyc=%b required 0 1", instr_valid_o, cyc_o);
    end
    s = adr_log.size();
    p = pop_pc.size();
    stall = 1'b0;
    instr_ready_i = 1'b1;
    ticks(12);
    checks++;
    if (adr_log.size() <= s) begin
      errors++;
      $display("FAIL redir_adr no new cycle required adr 00000100");
    end else if (adr_log[s] !== 32'h100) begin
      errors++;
      $display("FAIL redir_adr adr=%h required 00000100", adr_log[s]);
    end
    checks++;
    if (pop_pc.size() <= p) begin
      errors++;
      $display("FAIL redir_pop missing entry required pc 00000100");
    end else if (pop_pc[p] !== 32'h100 || pop_dat[p] !== 32'hFEFF_0100) begin
      errors++;
      $display("FAIL redir_pop pc=%h dat=%h required 00000100 feff0100", pop_pc[p], pop_dat[p]);
    end
  endtask

  task automatic test_retry();
    int s, p;
    restart(32'h8);
    rty_req = 3;
    s = adr_log.size();
    p = pop_pc.size();
    ticks(30);
    rty_req = 0;
    checks++;
    if (adr_log.size() < s + 5) begin
      errors++;
      $display("FAIL retry_cycles cycles=%0d required at least 5", adr_log.size() - s);
    end else if (adr_log[s] !== 32'h8 || adr_log[s+1] !== 32'h8 || adr_log[s+2] !== 32'h8 ||
                 adr_log[s+3] !== 32'h8 || adr_log[s+4] !== 32'hC) begin
      errors++;
      $display("FAIL retry_cycles adrs=%h %h %h %h %h required 8 8 8 8 c",
               adr_log[s], adr_log[s+1], adr_log[s+2], adr_log[s+3], adr_log[s+4]);
    end
    checks++;
    if (pop_pc.size() < p + 2) begin
      errors++;
      $display("FAIL retry_pop entries=%0d required 2", pop_pc.size() - p);
    end else if (pop_pc[p] !== 32'h8 || pop_dat[p] !== 32'hFFF7_0008 || pop_err[p] !== 1'b0 ||
                 pop_pc[p+1] !== 32'hC) begin
      errors++;
      $display("FAIL retry_pop pc=%h dat=%h err=%b next=%h required 00000008 fff70008 0 0000000c",
               pop_pc[p], pop_dat[p], pop_err[p], pop_pc[p+1]);
    end
  endtask

  task automatic test_retry_limit();
    int s, p;
    restart(32'h8);
    rty_forever = 1'b1;
    s = adr_log.size();
    p = pop_pc.size();
    ticks(35);
    checks++;
    if (adr_log.size() - s != 8 || adr_log[adr_log.size()-1] !== 32'h8) begin
      errors++;
      $display("FAIL rlim_cycles cycles=%0d required 8 on adr 00000008", adr_log.size() - s);
    end
    checks++;
    if (pop_pc.size() - p != 1) begin
      errors++;
      $display("FAIL rlim_pop entries=%0d required 1", pop_pc.size() - p);
    end else if (pop_pc[p] !== 32'h8 || pop_err[p] !== 1'b1 || pop_dat[p] !== 32'h0) begin
      errors++;
      $display("FAIL rlim_pop pc=%h err=%b dat=%h required 00000008 1 00000000", pop_pc[p], pop_err[p], pop_dat[p]);
    end
    ticks(10);
    checks++;
    if (cyc_o !== 1'b0 || adr_log.size() - s != 8) begin
      errors++;
      $display("FAIL rlim_halt cyc=%b cycles=%0d required 0 8", cyc_o, adr_log.size() - s);
    end
    rty_forever = 1'b0;
  endtask

  task automatic test_err();
    int s, p;
    err_en = 1'b1;
    err_adr = 32'h20;
    instr_ready_i = 1'b0;
    restart_halt(32'h20);
    s = adr_log.size();
    p = pop_pc.size();
    ticks(15);
    checks++;
    if (instr_valid_o !== 1'b1 || instr_err_o !== 1'b1 || instr_o !== 32'h0 || instr_pc_o !== 32'h20) begin
      errors++;
      $display("FAIL err_entry valid=%b err=%b instr=%h pc=%h required 1 1 00000000 00000020",
               instr_valid_o, instr_err_o, instr_o, instr_pc_o);
    end
    checks++;
    if (cyc_o !== 1'b0 || adr_log.size() - s != 1) begin
      errors++;
      $display("FAIL err_halt cyc=%b cycles=%0d required 0 1", cyc_o, adr_log.size() - s);
    end
    err_en = 1'b0;
    instr_ready_i = 1'b1;
    restart_halt(32'h40);
    ticks(10);
    checks++;
    if (adr_log.size() <= s + 1) begin
      errors++;
      $display("FAIL err_resume no cycle required adr 00000040");
    end else if (adr_log[s+1] !== 32'h40) begin
      errors++;
      $display("FAIL err_resume adr=%h required 00000040", adr_log[s+1]);
    end
    checks++;
    if (pop_pc.size() <= p) begin
      errors++;
      $display("FAIL err_resume_pop missing entry required pc 00000040");
    end else if (pop_pc[p] !== 32'h40 || pop_dat[p] !== 32'hFFBF_0040 || pop_err[p] !== 1'b0) begin
      errors++;
      $display("FAIL err_resume_pop pc=%h dat=%h err=%b required 00000040 ffbf0040 0", pop_pc[p], pop_dat[p], pop_err[p]);
    end
  endtask

  task automatic test_wrap();
    int s, p;
    restart(32'hFFFF_FFFC);
    s = adr_log.size();
    p = pop_pc.size();
    ticks(12);
    checks++;
    if (adr_log.size() < s + 2) begin
      errors++;
      $display("FAIL wrap_adr cycles=%0d required at least 2", adr_log.size() - s);
    end else if (adr_log[s] !== 32'hFFFF_FFFC || adr_log[s+1] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_adr adrs=%h %h required fffffffc 00000000", adr_log[s], adr_log[s+1]);
    end
    checks++;
    if (pop_pc.size() < p + 2) begin
      errors++;
      $display("FAIL wrap_pop entries=%0d required 2", pop_pc.size() - p);
    end else if (pop_pc[p] !== 32'hFFFF_FFFC || pop_dat[p] !== 32'h0003_FFFC ||
                 pop_pc[p+1] !== 32'h0 || pop_dat[p+1] !== 32'h1122_3344) begin
      errors++;
      $display("FAIL wrap_pop %h:%h %h:%h required fffffffc:0003fffc 00000000:11223344",
               pop_pc[p], pop_dat[p], pop_pc[p+1], pop_dat[p+1]);
    end
  endtask

  task automatic test_reset_mid_cycle();
    int n, s, p;
    instr_ready_i = 1'b1;
    stall = 1'b1;
    ticks(2);
    n = 0;
    while (!cyc_o && n < 40) begin
      tick();
      n++;
    end
    rst_i = 1'b1;
    tick();
    checks++;
    if (cyc_o !== 1'b0 || stb_o !== 1'b0 || instr_valid_o !== 1'b0 || adr_o !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_drop cyc=%b stb=%b valid=%b adr=%h required 0 0 0 00000000",
               cyc_o, stb_o, instr_valid_o, adr_o);
    end
    rst_i = 1'b0;
    stall = 1'b0;
    late_ack = 1'b1;
    s = adr_log.size();
    p = pop_pc.size();
    tick();
    late_ack = 1'b0;
    checks++;
    if (cyc_o !== 1'b1 || adr_o !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_restart cyc=%b adr=%h required 1 00000000", cyc_o, adr_o);
    end
    ticks(8);
    checks++;
    if (pop_pc.size() <= p) begin
      errors++;
      $display("FAIL rstmid_pop missing entry required pc 00000000");
    end else if (pop_pc[p] !== 32'h0 || pop_dat[p] !== 32'h1122_3344) begin
      errors++;
      $display("FAIL rstmid_pop pc=%h dat=%h required 00000000 11223344", pop_pc[p], pop_dat[p]);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_retry();
    test_retry_limit();
    test_err();
    test_wrap();
    test_reset_mid_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_fetch_unit.md
Name: wb_fetch_unit

Overview:
Instruction fetch stage, directly upstream of the flash emulator and any other big-endian wishbone slave. It issues classic single-read wishbone cycles at sequential word addresses and buffers the returned words in a small prefetch FIFO. The core consumes entries through a valid/ready handshake. Branches and jumps redirect the fetch PC and flush the FIFO.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
FIFO_DEPTH, 4, prefetch entries; power of two, 2..16
RETRY_LIMIT, 8, consecutive rty_i terminations tolerated before the fetch is reported as an error

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous reset, active high
redirect_i  in  1  load new fetch PC, flush FIFO
redirect_pc_i  in  32  new fetch PC; bits [1:0] ignored
instr_valid_o  out  1  FIFO head valid
instr_o  out  32  head instruction word, passed through unswapped
instr_pc_o  out  32  address the head word was fetched from
instr_err_o  out  1  head entry is a bus error marker; instr_o = 0
instr_ready_i  in  1  core pops head when instr_valid_o & instr_ready_i
cyc_o  out  1  wishbone cycle
stb_o  out  1  wishbone strobe, always equal to cyc_o
adr_o  out  32  byte address, bits [1:0] = 0
sel_o  out  4  constant 4'b1111
dat_o  out  32  constant 0
we_o  out  1  constant 0
dat_i  in  32  read data; may be Z except in the ack cycle
ack_i  in  1  normal termination
err_i  in  1  error termination
rty_i  in  1  retry termination

Behaviour:
- Reset values: cyc_o=stb_o=0, adr_o=RESET_PC, fetch_pc=RESET_PC, FIFO empty, instr_valid_o=0, retry count 0, state IDLE.
- Reset mid-cycle: cyc_o/stb_o drop at that edge. Any termination arriving later is ignored.
- Termination = ack_i|err_i|rty_i, sampled only while cyc_o=1. Priority when several are high: err > rty > ack.
- dat_i is sampled only on the edge where ack_i=1.
- Credit rule: a cycle starts only if (fifo_count + in_flight) < FIFO_DEPTH. A response therefore always has a slot.
- IDLE:
  - If there is credit, no halt and no redirect: set cyc/stb=1, adr_o=fetch_pc, go to BUS.
- BUS (cyc/stb held until termination):
  - ack: push {dat_i, adr_o, err=0}, fetch_pc+=4, clear retry count, drop cyc, go to IDLE.
  - rty: drop cyc, increment retry count, go to IDLE and reissue the same address. When the count reaches RETRY_LIMIT, act as err instead.
  - err: push {0, adr_o, err=1}, drop cyc, go to HALT.
- HALT: no bus activity until redirect_i.
- DISCARD: entered on redirect while in BUS. Holds cyc until termination, drops the response without pushing, then goes to IDLE.
- Minimum one idle cycle between bus cycles. Against a one-cycle-ack slave, throughput is 1 word per 3 clocks.
- Latency from the first edge with rst_i=0: cyc at E0, slave ack at E1, push at E2, instr_valid_o=1 after E2.
- Redirect (any state), same edge:
  - FIFO flushed; a simultaneous pop is discarded.
  - fetch_pc = {redirect_pc_i[31:2],2'b00}; retry count cleared.
  - HALT goes to IDLE; BUS goes to DISCARD.
  - The new request issues no earlier than the next edge.
- Redirect while in DISCARD: only fetch_pc is updated; the discard still completes.
- FIFO:
  - Head outputs come straight from the storage registers.
  - Push and pop on the same edge are both honoured.
  - Pointers wrap modulo FIFO_DEPTH; count is clog2(FIFO_DEPTH)+1 bits.
  - Pop when empty is ignored.
- fetch_pc wraps 32'hFFFF_FFFC to 0.
- instr_* outputs are held stable while instr_valid_o=1 and instr_ready_i=0.

Test Plan:
- Reset then stream against the flash emulator (BASE 0) holding words 0x11223344, 0x55667788, instr_ready_i=1 → instr_pc_o 0x0,0x4 in order with matching words; first instr_valid_o 2 clocks after the first cyc_o.
- instr_ready_i=0, FIFO_DEPTH=4 → exactly 4 bus cycles then cyc_o stays 0; raising ready pops 4 entries with PCs 0x0..0xC, then fetching resumes at 0x10.
- Redirect to 0x0000_0102 while in BUS → current ack discarded, FIFO empty next cycle, next adr_o = 0x0000_0100, first popped PC 0x100.
- Slave returns rty 3 times then ack at 0x8 → 4 cycles on adr 0x8, one entry pushed. With RETRY_LIMIT=3 and rty forever → err entry at PC 0x8, then no cyc_o until redirect.
- err_i at 0x20 → entry with instr_err_o=1, instr_o=0, instr_pc_o=0x20; no further cycles; redirect to 0x40 resumes fetching.
- Reset asserted while cyc_o=1 → cyc_o=0 after that edge; late ack not pushed; after release, fetching restarts at RESET_PC.
